// File: rtl/remote_cmd_tx_if.sv
// Command-link bundle between the remote stimulus logic, the UART tx/rx pair
// and remote_cmd_tx. The stimulus/UART side uses master; remote_cmd_tx uses slave.
interface remote_cmd_tx_if;
  logic        snd_cmd;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic        busy;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;
  logic        timeout;

  modport master (
    output snd_cmd, cmd, data, tx_done, rx_rdy, rx_data,
    input  tx_data, trmt, clr_rx_rdy, busy, cmd_sent, resp_rdy, resp, timeout
  );

  modport slave (
    input  snd_cmd, cmd, data, tx_done, rx_rdy, rx_data,
    output tx_data, trmt, clr_rx_rdy, busy, cmd_sent, resp_rdy, resp, timeout
  );
endinterface

// File: rtl/remote_cmd_tx.sv
// Ground-station command sender: opcode + 16-bit data as three UART bytes, then one response byte.
// Optional response timeout is enabled by defining RESP_TIMEOUT_EN.
module remote_cmd_tx #(
  parameter int unsigned FAST_SIM = 1
) (
  input logic          clk,
  input logic          rst_n,
  remote_cmd_tx_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    TX_CMD,
    TX_HI,
    TX_LO,
    WAIT_RESP
  } state_t;

  localparam int unsigned TW = (FAST_SIM != 0) ? 9 : 26;

  state_t      r_state,      w_state_nxt;
  logic [7:0]  r_tx_data,    w_tx_data_nxt;
  logic        r_trmt,       w_trmt_nxt;
  logic        r_armed,      w_armed_nxt;
  logic        r_busy,       w_busy_nxt;
  logic        r_cmd_sent,   w_cmd_sent_nxt;
  logic        r_resp_rdy,   w_resp_rdy_nxt;
  logic [7:0]  r_resp,       w_resp_nxt;
  logic        r_clr_rx_rdy, w_clr_rx_rdy_nxt;
  logic [15:0] r_data,       w_data_nxt;
  logic        w_rx_new;

`ifdef RESP_TIMEOUT_EN
  logic [TW-1:0] r_timer,   w_timer_nxt;
  logic          r_timeout, w_timeout_nxt;
`endif

  // rx_rdy is still high in the cycle we clear it; do not treat that as a new byte
  assign w_rx_new = bus.rx_rdy & ~r_clr_rx_rdy;

  always_comb begin
    w_state_nxt      = r_state;
    w_tx_data_nxt    = r_tx_data;
    w_trmt_nxt       = 1'b0;
    w_armed_nxt      = r_armed;
    w_busy_nxt       = r_busy;
    w_cmd_sent_nxt   = 1'b0;
    w_resp_rdy_nxt   = 1'b0;
    w_resp_nxt       = r_resp;
    w_clr_rx_rdy_nxt = 1'b0;
    w_data_nxt       = r_data;
`ifdef RESP_TIMEOUT_EN
    w_timer_nxt      = '0;
    w_timeout_nxt    = 1'b0;
`endif

    unique case (r_state)
      IDLE: begin
        if (bus.snd_cmd) begin
          w_tx_data_nxt = bus.cmd;
          w_data_nxt    = bus.data;
          w_trmt_nxt    = 1'b1;
          w_armed_nxt   = 1'b0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = TX_CMD;
        end
      end

      TX_CMD, TX_HI, TX_LO: begin
        // tx_done only counts once this byte's trmt has been issued
        if (r_trmt) begin
          w_armed_nxt = 1'b1;
        end else if (r_armed && bus.tx_done) begin
          w_armed_nxt = 1'b0;
          unique case (r_state)
            TX_CMD: begin
              w_tx_data_nxt = r_data[15:8];
              w_trmt_nxt    = 1'b1;
              w_state_nxt   = TX_HI;
            end
            TX_HI: begin
              w_tx_data_nxt = r_data[7:0];
              w_trmt_nxt    = 1'b1;
              w_state_nxt   = TX_LO;
            end
            default: begin
              w_cmd_sent_nxt = 1'b1;
              w_state_nxt    = WAIT_RESP;
            end
          endcase
        end
      end

      WAIT_RESP: begin
        if (w_rx_new) begin
          w_resp_nxt       = bus.rx_data;
          w_resp_rdy_nxt   = 1'b1;
          w_clr_rx_rdy_nxt = 1'b1;
          w_busy_nxt       = 1'b0;
          w_state_nxt      = IDLE;
        end
`ifdef RESP_TIMEOUT_EN
        else if (&r_timer) begin
          w_timeout_nxt = 1'b1;
          w_busy_nxt    = 1'b0;
          w_state_nxt   = IDLE;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
`endif
      end

      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // stray byte outside WAIT_RESP: discard it without touching resp
    if (r_state != WAIT_RESP && w_rx_new) begin
      w_clr_rx_rdy_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_tx_data    <= '0;
      r_trmt       <= 1'b0;
      r_armed      <= 1'b0;
      r_busy       <= 1'b0;
      r_cmd_sent   <= 1'b0;
      r_resp_rdy   <= 1'b0;
      r_resp       <= '0;
      r_clr_rx_rdy <= 1'b0;
      r_data       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_trmt       <= w_trmt_nxt;
      r_armed      <= w_armed_nxt;
      r_busy       <= w_busy_nxt;
      r_cmd_sent   <= w_cmd_sent_nxt;
      r_resp_rdy   <= w_resp_rdy_nxt;
      r_resp       <= w_resp_nxt;
      r_clr_rx_rdy <= w_clr_rx_rdy_nxt;
      r_data       <= w_data_nxt;
    end
  end

`ifdef RESP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timer   <= w_timer_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.timeout = r_timeout;
`else
  // TW is never zero, so timeout is constant low without a timer
  assign bus.timeout = (TW == 0);
`endif

  assign bus.tx_data    = r_tx_data;
  assign bus.trmt       = r_trmt;
  assign bus.clr_rx_rdy = r_clr_rx_rdy;
  assign bus.busy       = r_busy;
  assign bus.cmd_sent   = r_cmd_sent;
  assign bus.resp_rdy   = r_resp_rdy;
  assign bus.resp       = r_resp;

endmodule

// File: tb/tb_remote_cmd_tx.sv
// Scoreboard bench for remote_cmd_tx: stimulus pushes expected bytes/pulses, a monitor pops and compares.
module tb_remote_cmd_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  remote_cmd_tx_if bus ();

  remote_cmd_tx #(.FAST_SIM(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int trmt_cnt = 0;
  int tx_delay = 1;

  logic [7:0] q_tx[$];
  logic [7:0] q_resp[$];
  int         q_sent[$];
  int         q_clr[$];
  int         q_to[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every DUT pulse must match a queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.trmt) begin
        trmt_cnt++;
        if (q_tx.size() == 0) chk("trmt_unexpected", q_tx.size(), 1);
        else chk("tx_byte", bus.tx_data, q_tx.pop_front());
      end
      if (bus.cmd_sent) begin
        chk("cmd_sent_expected", q_sent.size() > 0, 1);
        if (q_sent.size() > 0) void'(q_sent.pop_front());
      end
      if (bus.resp_rdy) begin
        if (q_resp.size() == 0) chk("resp_rdy_unexpected", q_resp.size(), 1);
        else chk("resp", bus.resp, q_resp.pop_front());
      end
      if (bus.clr_rx_rdy) begin
        chk("clr_rx_rdy_expected", q_clr.size() > 0, 1);
        if (q_clr.size() > 0) void'(q_clr.pop_front());
      end
      if (bus.timeout) begin
        chk("timeout_expected", q_to.size() > 0, 1);
        if (q_to.size() > 0) void'(q_to.pop_front());
      end
    end
  end

  // UART tx model: tx_done tx_delay cycles after trmt; tx_data must hold meanwhile
  initial begin : uart_tx
    logic [7:0] b;
    bit ok;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (bus.trmt && rst_n) begin
        b  = bus.tx_data;
        ok = 1'b1;
        for (int i = 0; i < tx_delay; i++) begin
          @(negedge clk);
          if (!rst_n) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok) begin
          chk("tx_data_stable", bus.tx_data, b);
          bus.tx_done = 1'b1;
        end
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_tx_data",    bus.tx_data,    8'h00);
    chk("rst_trmt",       bus.trmt,       1'b0);
    chk("rst_clr_rx_rdy", bus.clr_rx_rdy, 1'b0);
    chk("rst_busy",       bus.busy,       1'b0);
    chk("rst_cmd_sent",   bus.cmd_sent,   1'b0);
    chk("rst_resp_rdy",   bus.resp_rdy,   1'b0);
    chk("rst_resp",       bus.resp,       8'h00);
    chk("rst_timeout",    bus.timeout,    1'b0);
  endtask

  // Called right after a negedge; returns at the negedge where cmd_sent is seen
  task automatic send_cmd(input logic [7:0] c, input logic [15:0] d, input int inj_n);
    int n;
    bus.snd_cmd = 1'b1;
    bus.cmd     = c;
    bus.data    = d;
    q_tx.push_back(c);
    q_tx.push_back(d[15:8]);
    q_tx.push_back(d[7:0]);
    q_sent.push_back(1);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (n == 1 || n == inj_n + 1) bus.snd_cmd = 1'b0;
      if (n == inj_n) begin
        bus.snd_cmd = 1'b1;
        bus.cmd     = 8'h05;
        bus.data    = 16'hFFFF;
      end
      if (bus.cmd_sent) break;
      if (n > 400) break;
    end
    bus.snd_cmd = 1'b0;
    chk("cmd_sent_latency", n, 3 * (tx_delay + 1) + 1);
    chk("busy_at_cmd_sent", bus.busy, 1'b1);
  endtask

  // Deliver one received byte; is_resp means the DUT is in WAIT_RESP
  task automatic rx_byte(input logic [7:0] b, input bit is_resp, input bit also_snd);
    int n;
    bus.rx_rdy  = 1'b1;
    bus.rx_data = b;
    if (also_snd) begin
      bus.snd_cmd = 1'b1;
      bus.cmd     = 8'h77;
      bus.data    = 16'h7777;
    end
    if (is_resp) q_resp.push_back(b);
    q_clr.push_back(1);
    n = 0;
    forever begin
      @(negedge clk);
      bus.snd_cmd = 1'b0;
      n++;
      if (bus.clr_rx_rdy || n > 20) break;
    end
    chk("clr_rx_rdy_latency", n, 1);
    if (is_resp) chk("busy_after_resp", bus.busy, 1'b0);
    // a real UART drops rx_rdy only after the clearing edge
    @(posedge clk);
    #1 bus.rx_rdy = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    int n;
    int c0;
    bus.snd_cmd = 1'b0;
    bus.cmd     = 8'h00;
    bus.data    = 16'h0000;
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // stray byte while idle
    rx_byte(8'h5A, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("resp_after_stray", bus.resp, 8'h00);

    // basic command and ack
    tx_delay = 1;
    send_cmd(8'h02, 16'h1234, -10);
    repeat (3) @(negedge clk);
    rx_byte(8'hA5, 1'b1, 1'b0);
    chk("resp_hold", bus.resp, 8'hA5);
    chk("busy_idle", bus.busy, 1'b0);

    // snd_cmd during TX_HI ignored; snd_cmd on response cycle ignored
    tx_delay = 3;
    send_cmd(8'h10, 16'hBEEF, 6);
    repeat (2) @(negedge clk);
    c0 = trmt_cnt;
    rx_byte(8'h3C, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    chk("no_trmt_after_late_snd", trmt_cnt, c0);
    chk("busy_stays_low", bus.busy, 1'b0);
    chk("resp_3c", bus.resp, 8'h3C);

    tx_delay = 1;
`ifdef RESP_TIMEOUT_EN
    send_cmd(8'h20, 16'h0001, -10);
    q_to.push_back(1);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (bus.timeout || n > 600) break;
    end
    chk("timeout_cycles", n, 512);
    chk("busy_at_timeout", bus.busy, 1'b0);
    chk("resp_after_timeout", bus.resp, 8'h3C);
    repeat (3) @(negedge clk);
    send_cmd(8'h21, 16'h0002, -10);
    repeat (511) @(negedge clk);
    rx_byte(8'hC3, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("resp_on_last_cycle", bus.resp, 8'hC3);
`else
    send_cmd(8'h20, 16'h0001, -10);
    repeat (600) @(negedge clk);
    chk("still_waiting", bus.busy, 1'b1);
    chk("timeout_low", bus.timeout, 1'b0);
    rx_byte(8'hC3, 1'b1, 1'b0);
    chk("resp_late", bus.resp, 8'hC3);
`endif

    // reset in the middle of TX_CMD
    tx_delay = 4;
    repeat (2) @(negedge clk);
    bus.snd_cmd = 1'b1;
    bus.cmd     = 8'h40;
    bus.data    = 16'h4142;
    q_tx.push_back(8'h40);
    @(negedge clk);
    bus.snd_cmd = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    q_tx.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c0 = trmt_cnt;
    repeat (15) @(negedge clk);
    chk("no_trmt_after_reset", trmt_cnt, c0);
    chk("idle_after_reset", bus.busy, 1'b0);

    send_cmd(8'h0F, 16'hA55A, -10);
    rx_byte(8'hA5, 1'b1, 1'b0);

    repeat (5) @(negedge clk);
    chk("queues_drained",
        q_tx.size() + q_resp.size() + q_sent.size() + q_clr.size() + q_to.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
